// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate with clear/last framing, optional saturation,
// sticky overflow and configurable output delay.
module mac_pipe #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 33,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0,
  parameter int EXTRA_PIPE = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              valid_i,
  input  logic              clear_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              ovf_o
);
  localparam int PW = 2 * DATA_W;
  logic [DATA_W-1:0] a1, b1;
  logic v1, c1, l1;
  logic [PW-1:0] p2;
  logic v2, c2, l2;
  logic [ACC_W-1:0] acc;
  logic v3, l3, ov3;
  logic [ACC_W-1:0] res_q [EXTRA_PIPE+1];
  logic vq [EXTRA_PIPE+1];
  logic lq [EXTRA_PIPE+1];
  logic oq [EXTRA_PIPE+1];
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0] prod_u, prod;
  logic [ACC_W:0] ext, base, sum;
  logic sx, ovf_now;
  logic [ACC_W-1:0] sat_val, acc_nxt;
  // One guard bit above the accumulator exposes carry-out (unsigned) or sign disagreement (signed).
  always_comb begin
    prod_s  = PW'($signed(a1)) * PW'($signed(b1));
    prod_u  = PW'(a1) * PW'(b1);
    prod    = (SIGNED != 0) ? prod_s : prod_u;
    sx      = (SIGNED != 0) & p2[PW-1];
    ext     = {{(ACC_W+1-PW){sx}}, p2};
    base    = c2 ? '0 : {(SIGNED != 0) & acc[ACC_W-1], acc};
    sum     = base + ext;
    ovf_now = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    sat_val = (SIGNED != 0) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : '1;
    acc_nxt = ((SATURATE != 0) && ovf_now) ? sat_val : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a1  <= '0;
      b1  <= '0;
      v1  <= 1'b0;
      c1  <= 1'b0;
      l1  <= 1'b0;
      p2  <= '0;
      v2  <= 1'b0;
      c2  <= 1'b0;
      l2  <= 1'b0;
      acc <= '0;
      v3  <= 1'b0;
      l3  <= 1'b0;
      ov3 <= 1'b0;
      for (int i = 0; i <= EXTRA_PIPE; i++) begin
        res_q[i] <= '0;
        vq[i]    <= 1'b0;
        lq[i]    <= 1'b0;
        oq[i]    <= 1'b0;
      end
    end else if (clk_en_i) begin
      a1 <= data_a_i;
      b1 <= data_b_i;
      v1 <= valid_i;
      c1 <= valid_i & clear_i;
      l1 <= valid_i & last_i;
      p2 <= prod;
      v2 <= v1;
      c2 <= c1;
      l2 <= l1;
      v3 <= v2;
      l3 <= l2;
      if (v2) begin
        acc <= acc_nxt;
        ov3 <= ovf_now | (~c2 & ov3);
      end
      res_q[0] <= acc;
      vq[0]    <= v3;
      lq[0]    <= l3;
      oq[0]    <= ov3;
      for (int i = 1; i <= EXTRA_PIPE; i++) begin
        res_q[i] <= res_q[i-1];
        vq[i]    <= vq[i-1];
        lq[i]    <= lq[i-1];
        oq[i]    <= oq[i-1];
      end
    end
  end
  assign result_o = res_q[EXTRA_PIPE];
  assign valid_o  = clk_en_i & vq[EXTRA_PIPE];
  assign last_o   = clk_en_i & lq[EXTRA_PIPE];
  assign ovf_o    = oq[EXTRA_PIPE];
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: four mac_pipe configurations driven in parallel and checked against
// an arithmetic reference model of accumulate-then-delay behaviour.
module tb_mac_pipe;
  typedef struct packed {
    logic        v;
    logic        l;
    logic        o;
    logic [32:0] r;
  } rec_t;
  localparam bit [3:0] SG = 4'b1100;
  localparam bit [3:0] ST = 4'b1010;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic en = 1'b0, v = 1'b0, c = 1'b0, l = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [32:0] res [4];
  logic vo [4];
  logic lo [4];
  logic oo [4];
  rec_t hist [4][8];
  longint macc [4];
  bit movf [4];
  int n_asrt = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mac_pipe #(.SIGNED(0), .SATURATE(0), .EXTRA_PIPE(0)) u0 (
    .clk_i(clk), .rst_i(rst_i), .clk_en_i(en), .valid_i(v), .clear_i(c), .last_i(l),
    .data_a_i(a), .data_b_i(b), .result_o(res[0]), .valid_o(vo[0]), .last_o(lo[0]), .ovf_o(oo[0]));
  mac_pipe #(.SIGNED(0), .SATURATE(1), .EXTRA_PIPE(0)) u1 (
    .clk_i(clk), .rst_i(rst_i), .clk_en_i(en), .valid_i(v), .clear_i(c), .last_i(l),
    .data_a_i(a), .data_b_i(b), .result_o(res[1]), .valid_o(vo[1]), .last_o(lo[1]), .ovf_o(oo[1]));
  mac_pipe #(.SIGNED(1), .SATURATE(0), .EXTRA_PIPE(2)) u2 (
    .clk_i(clk), .rst_i(rst_i), .clk_en_i(en), .valid_i(v), .clear_i(c), .last_i(l),
    .data_a_i(a), .data_b_i(b), .result_o(res[2]), .valid_o(vo[2]), .last_o(lo[2]), .ovf_o(oo[2]));
  mac_pipe #(.SIGNED(1), .SATURATE(1), .EXTRA_PIPE(1)) u3 (
    .clk_i(clk), .rst_i(rst_i), .clk_en_i(en), .valid_i(v), .clear_i(c), .last_i(l),
    .data_a_i(a), .data_b_i(b), .result_o(res[3]), .valid_o(vo[3]), .last_o(lo[3]), .ovf_o(oo[3]));
  function automatic int lat(input int d);
    return d == 2 ? 5 : d == 3 ? 4 : 3;
  endfunction
  // Exact integer sum, then range test against the 33-bit accumulator; wrap or clamp.
  function automatic void acc_step(input bit sg, input bit st, input logic [15:0] x, input logic [15:0] y,
                                   input bit clr, inout longint acc, inout bit ov);
    longint p, s, lo_b, hi_b, m;
    bit o;
    m    = longint'(1) << 33;
    p    = sg ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
    s    = (clr ? longint'(0) : acc) + p;
    lo_b = sg ? -(m / 2) : 0;
    hi_b = sg ? m / 2 - 1 : m - 1;
    o    = (s < lo_b) || (s > hi_b);
    if (o && st) s = (s > hi_b) ? hi_b : lo_b;
    else if (o) begin
      s = s & (m - 1);
      if (sg && s > hi_b) s = s - m;
    end
    acc = s;
    ov  = (clr ? 1'b0 : ov) | o;
  endfunction
  task automatic chk(input string tag, input int d, input logic [32:0] got, input logic [32:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, got, exp);
    end
  endtask
  task automatic check_all();
    rec_t e;
    for (int d = 0; d < 4; d++) begin
      e = hist[d][lat(d)];
      chk("result", d, res[d], e.r);
      chk("valid", d, 33'(vo[d]), 33'(en & e.v));
      chk("last", d, 33'(lo[d]), 33'(en & e.l));
      chk("ovf", d, 33'(oo[d]), 33'(e.o));
    end
  endtask
  task automatic step(input bit e_, input bit v_, input bit c_, input bit l_, input logic [15:0] a_, input logic [15:0] b_);
    en = e_; v = v_; c = c_; l = v_ & l_; a = a_; b = b_;
    @(posedge clk);
    if (e_) begin
      for (int d = 0; d < 4; d++) begin
        for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
        if (v_) acc_step(SG[d], ST[d], a_, b_, c_, macc[d], movf[d]);
        hist[d][0] = '{v: v_, l: v_ & l_, o: movf[d], r: 33'(macc[d])};
      end
    end
    #1 check_all();
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask
  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rst_i = 1'b1;
    for (int d = 0; d < 4; d++) begin
      macc[d] = 0;
      movf[d] = 1'b0;
      for (int i = 0; i < 8; i++) hist[d][i] = '0;
    end
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    rst_i = 1'b0;
  endtask
  initial begin
    bit re, rv, rc, rl;
    logic [15:0] ra, rb;
    #2 do_reset();
    step(1, 1, 1, 0, 16'd3, 16'd4);
    step(1, 1, 0, 1, 16'd5, 16'd6);
    idle(2);
    chk("basic_r12", 0, res[0], 33'd12);
    chk("basic_v12", 0, 33'(vo[0]), 33'd1);
    chk("basic_l12", 0, 33'(lo[0]), 33'd0);
    idle(1);
    chk("basic_r42", 0, res[0], 33'd42);
    chk("basic_l42", 0, 33'(lo[0]), 33'd1);
    idle(1);
    chk("basic_vend", 0, 33'(vo[0]), 33'd0);
    step(1, 1, 1, 0, 16'd3, 16'd4);
    step(0, 1, 1, 1, 16'd7, 16'd9);
    step(0, 1, 0, 0, 16'd8, 16'd8);
    step(1, 1, 0, 1, 16'd5, 16'd6);
    idle(2);
    chk("stall_r12", 0, res[0], 33'd12);
    idle(1);
    chk("stall_r42", 0, res[0], 33'd42);
    idle(2);
    step(1, 1, 1, 0, 16'hFFFF, 16'hFFFF);
    step(1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
    step(1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
    idle(3);
    chk("wrap_r3", 0, res[0], 33'd4294574083);
    chk("wrap_ovf", 0, 33'(oo[0]), 33'd1);
    chk("sat_r3", 1, res[1], 33'h1_FFFF_FFFF);
    chk("sat_ovf", 1, 33'(oo[1]), 33'd1);
    step(1, 1, 1, 1, 16'd1, 16'd1);
    idle(3);
    chk("clr_r1", 0, res[0], 33'd1);
    chk("clr_ovf", 0, 33'(oo[0]), 33'd0);
    chk("clr_sat_r1", 1, res[1], 33'd1);
    step(1, 1, 1, 0, 16'hFFFD, 16'd5);
    step(1, 1, 0, 0, 16'd2, 16'd2);
    idle(4);
    chk("signed_m11", 3, res[3], 33'h1_FFFF_FFF5);
    idle(1);
    chk("signed_m11", 2, res[2], 33'h1_FFFF_FFF5);
    idle(2);
    step(1, 1, 1, 0, 16'h8000, 16'h8000);
    repeat (4) step(1, 1, 0, 0, 16'h8000, 16'h8000);
    step(1, 1, 0, 1, 16'h7FFF, 16'h8000);
    idle(6);
    step(1, 1, 1, 0, 16'd3, 16'd4);
    step(1, 0, 0, 0, 16'd0, 16'd0);
    do_reset();
    step(1, 1, 0, 0, 16'd2, 16'd2);
    idle(3);
    chk("rst_r4", 0, res[0], 33'd4);
    chk("rst_v4", 0, 33'(vo[0]), 33'd1);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      re = $urandom_range(0, 9) != 0;
      rv = $urandom_range(0, 3) != 0;
      rc = $urandom_range(0, 7) == 0;
      rl = $urandom_range(0, 5) == 0;
      ra = $urandom_range(0, 2) == 0 ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      rb = $urandom_range(0, 2) == 0 ? 16'h8000 + 16'($urandom_range(0, 1)) : 16'($urandom);
      if (i == 200) do_reset();
      step(re, rv, rc, rl, ra, rb);
    end
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
